pipelined_cla_adder: RTL and testbench



---
 rtl/pipelined_cla_adder_if.sv | 31 +++
 rtl/pipelined_cla_adder.sv | 147 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Handshake/data bundle for pipelined_cla_adder.
// Ports (slave = adder side):
//   in_valid/in_ready      operation offer / accept
//   a, b, cin, sub         operands, carry-in, subtract select
//   out_valid/out_ready    result present / consumer takes it
//   sum, cout, ovf         result, MSB carry-out, signed overflow
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One BLOCK-bit lookahead group is resolved per stage; the group carry is
// registered between stages. Latency and depth are NGRP = WIDTH/BLOCK.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   pipelined_cla_adder_if.slave (valid/ready in, valid/ready out)
// Optional feature: define PIPELINED_CLA_OVF_EN to build the signed
// overflow output; otherwise ovf is tied to 0.
module pipelined_cla_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_cla_adder_if.slave bus
);

   localparam int NGRP = WIDTH / BLOCK;

   // Flat lookahead: every carry is a sum of products of g/p and c0,
   // so there is no ripple inside the group. Returns {carry_out, sum}.
   function automatic logic [BLOCK:0] cla_group(
      input logic [BLOCK-1:0] x,
      input logic [BLOCK-1:0] y,
      input logic             c0
   );
      logic [BLOCK-1:0] p;
      logic [BLOCK-1:0] g;
      logic [BLOCK:0]   c;
      logic             term;
      p    = x ^ y;
      g    = x & y;
      c    = '0;
      c[0] = c0;
      for (int i = 0; i < BLOCK; i++) begin
         c[i+1] = 1'b0;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int k = j + 1; k <= i; k++) term = term & p[k];
            c[i+1] = c[i+1] | term;
         end
         term = c0;
         for (int k = 0; k <= i; k++) term = term & p[k];
         c[i+1] = c[i+1] | term;
      end
      return {c[BLOCK], p ^ c[BLOCK-1:0]};
   endfunction

   logic             stall;
   logic [WIDTH-1:0] b_op;
   logic             c_op;

   logic             q_valid [NGRP];
   logic [WIDTH-1:0] q_sum   [NGRP];
   logic [WIDTH-1:0] q_a     [NGRP];
   logic [WIDTH-1:0] q_b     [NGRP];
   logic             q_c     [NGRP];

   logic             d_valid [NGRP];
   logic [WIDTH-1:0] d_sum   [NGRP];
   logic [WIDTH-1:0] d_a     [NGRP];
   logic [WIDTH-1:0] d_b     [NGRP];
   logic             d_c     [NGRP];
   logic [BLOCK:0]   grp     [NGRP];

   assign stall         = bus.out_valid && !bus.out_ready;
   assign bus.in_ready  = !stall;
   assign bus.out_valid = q_valid[NGRP-1];
   assign bus.sum       = q_sum[NGRP-1];
   assign bus.cout      = q_c[NGRP-1];

   // Subtract is A + ~B + 1; cin is ignored in that mode.
   always_comb begin
      b_op = bus.sub ? ~bus.b : bus.b;
      c_op = bus.sub ? 1'b1 : bus.cin;
   end

   // Stage 0 resolves group 0 straight from the accepted operands, so an
   // operation accepted on edge N is in the output register after N+NGRP-1.
   // Operands travel whole; resolved low bits are simply not used downstream.
   always_comb begin
      grp[0]              = cla_group(bus.a[BLOCK-1:0], b_op[BLOCK-1:0], c_op);
      d_valid[0]          = bus.in_valid;
      d_a[0]              = bus.a;
      d_b[0]              = b_op;
      d_sum[0]            = '0;
      d_sum[0][BLOCK-1:0] = grp[0][BLOCK-1:0];
      d_c[0]              = grp[0][BLOCK];
      for (int k = 1; k < NGRP; k++) begin
         grp[k]     = cla_group(q_a[k-1][k*BLOCK +: BLOCK],
                                q_b[k-1][k*BLOCK +: BLOCK], q_c[k-1]);
         d_valid[k] = q_valid[k-1];
         d_a[k]     = q_a[k-1];
         d_b[k]     = q_b[k-1];
         d_sum[k]   = q_sum[k-1];
         d_sum[k][k*BLOCK +: BLOCK] = grp[k][BLOCK-1:0];
         d_c[k]     = grp[k][BLOCK];
      end
   end

   // Global stall: the whole pipe, bubbles included, freezes together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NGRP; k++) begin
            q_valid[k] <= 1'b0;
            q_sum[k]   <= '0;
            q_a[k]     <= '0;
            q_b[k]     <= '0;
            q_c[k]     <= 1'b0;
         end
      end else if (!stall) begin
         for (int k = 0; k < NGRP; k++) begin
            q_valid[k] <= d_valid[k];
            q_sum[k]   <= d_sum[k];
            q_a[k]     <= d_a[k];
            q_b[k]     <= d_b[k];
            q_c[k]     <= d_c[k];
         end
      end
   end

`ifdef PIPELINED_CLA_OVF_EN
   // The operand MSBs ride along as unresolved upper bits until the last
   // stage, where like-signed operands giving an unlike-signed sum flag ovf.
   logic ovf_d;
   logic ovf_q;

   always_comb begin
      ovf_d = (d_a[NGRP-1][WIDTH-1] == d_b[NGRP-1][WIDTH-1]) &&
              (d_sum[NGRP-1][WIDTH-1] != d_a[NGRP-1][WIDTH-1]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (!stall) begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

   localparam int WIDTH = 16;
   localparam int BLOCK = 4;
   localparam int NGRP  = WIDTH / BLOCK;
`ifdef PIPELINED_CLA_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic clk;
   logic rst;

   pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

   pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [17:0] exp_q[$];
   logic        pend;
   int          sent, recv, send_limit, ir_low_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sb);
      logic [15:0] bb;
      logic [16:0] r;
      logic        c;
      logic        ov;
      bb = sb ? ~b : b;
      c  = sb ? 1'b1 : ci;
      r  = {1'b0, a} + {1'b0, bb} + {16'd0, c};
      ov = (a[15] == bb[15]) && (r[15] != a[15]);
      return {ov & OVF_ON, r[16], r[15:0]};
   endfunction

   // Single isolated operation with hand-computed expectations and latency check.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo);
      bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 0; i < NGRP - 1; i++) begin
         check({tag, "_early"}, bus.out_valid, 1'b0);
         @(negedge clk);
      end
      check({tag, "_valid"}, bus.out_valid, 1'b1);
      check({tag, "_sum"}, bus.sum, es);
      check({tag, "_cout"}, bus.cout, ec);
      check({tag, "_ovf"}, bus.ovf, eo & OVF_ON);
      @(negedge clk);
   endtask

   // One streaming cycle, called at a negedge.
   task automatic step(input logic rdy, input logic want);
      logic exp_rdy;
      if (bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) check("spurious_out", 1'b1, 1'b0);
         else check("stream_result", {bus.ovf, bus.cout, bus.sum}, exp_q[0]);
      end
      bus.out_ready = rdy;
      if (bus.out_valid === 1'b1 && rdy && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         recv++;
      end
      if (!pend) begin
         if (want && sent < send_limit) begin
            bus.a   = 16'($urandom);
            bus.b   = 16'($urandom);
            bus.cin = 1'($urandom_range(0, 1));
            bus.sub = 1'($urandom_range(0, 1));
            bus.in_valid = 1'b1;
            pend = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      exp_rdy = !(bus.out_valid && !rdy);
      if (pend && exp_rdy) begin
         exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
         pend = 1'b0;
         sent++;
      end
      #1;
      check("in_ready", bus.in_ready, exp_rdy);
      if (bus.in_ready === 1'b0) ir_low_cnt++;
      @(negedge clk);
   endtask

   initial begin
      int  first_cyc;
      int  stall_left;
      logic rdy;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      pend = 1'b0; sent = 0; recv = 0; send_limit = 0; ir_low_cnt = 0;
      #1;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_sum", bus.sum, 16'h0000);
      check("post_rst_cout", bus.cout, 1'b0);
      check("post_rst_ovf", bus.ovf, 1'b0);
      check("post_rst_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);

      // Directed vectors
      do_op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op("sub_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      do_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op("add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
      do_op("sub_zero",    16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      do_op("neg_ovf",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      check("idle_after_directed", bus.out_valid, 1'b0);

      // Backpressure: 8 back-to-back ops, 3-cycle stall at first result
      exp_q.delete(); pend = 1'b0; sent = 0; recv = 0; send_limit = 8; ir_low_cnt = 0;
      first_cyc = -1; stall_left = 0;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         rdy = 1'b1;
         if (bus.out_valid === 1'b1 && first_cyc < 0) begin
            first_cyc  = cyc;
            stall_left = 3;
         end
         if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end
         step(rdy, 1'b1);
      end
      check("bp_first_latency", first_cyc, 4);
      check("bp_received", recv, 8);
      check("bp_in_ready_low_cycles", ir_low_cnt, 3);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(negedge clk);

      // Reset while a stalled result is on the output
      bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (NGRP) @(negedge clk);
      check("held_valid", bus.out_valid, 1'b1);
      check("held_sum", bus.sum, 16'h0003);
      check("held_in_ready", bus.in_ready, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", bus.out_valid, 1'b0);
      check("async_rst_sum", bus.sum, 16'h0000);
      check("async_rst_in_ready", bus.in_ready, 1'b1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset mid-flight with two operations inside
      bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.a = 16'h3333; bus.b = 16'h0001;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midflight_valid", bus.out_valid, 1'b0);
      check("midflight_in_ready", bus.in_ready, 1'b1);
      repeat (2) begin
         @(negedge clk);
         check("midflight_hold_valid", bus.out_valid, 1'b0);
      end
      rst = 1'b0;
      for (int i = 0; i < NGRP + 2; i++) begin
         @(negedge clk);
         check("no_stale", bus.out_valid, 1'b0);
      end
      do_op("after_rst", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Random soak
      exp_q.delete(); pend = 1'b0; sent = 0; recv = 0; send_limit = 10000;
      for (int cyc = 0; cyc < 60000 && recv < 10000; cyc++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      end
      check("soak_received", recv, 10000);
      check("soak_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
